// File: rtl/data_types_pkg.sv
// Shared types for the UART/control-register slice: byte, FSM state and the
// control register image, plus UART framing constants.
package data_types_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // word: 1 = 8 data bits, 0 = 7 data bits; stop: 0 = one stop bit, 1 = two
  typedef struct packed {
    logic  en;
    logic  word;
    logic  stop;
    byte_t br_div;
  } ctrl_reg_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MAX_BITS   = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate prescaler: counts 0..br_div and pulses tick on the terminal count.
// Shared between the TX stage and the future RX stage.
module uart_baud_gen
  import data_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  byte_t br_div,
  output logic  tick
);

  byte_t div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == br_div)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign tick = ~clr & (div_cnt == br_div);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: accepts a byte via valid/ready, then shifts out start,
// 7 or 8 data bits LSB-first and 1 or 2 stop bits on the serial line.
module uart_tx_serializer
  import data_types_pkg::*;
#(
  parameter int   OVERSAMPLE = UART_OVERSAMPLE,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  ctrl_reg_t ctrl,
  input  byte_t     tx_data,
  input  logic      tx_valid,
  output logic      tx_ready,
  output logic      tx,
  output logic      txe,
  output logic      tx_done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  state_t            state;
  state_t            state_next;
  byte_t             shadow_data;
  logic              shadow_word;
  logic              shadow_stop;
  byte_t             shadow_br_div;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        last_idx;
  logic              stop_cnt;
  logic              tick;
  logic              boundary;
  logic              handshake;
  logic              idle;

  assign idle      = (state == IDLE);
  assign tx_ready  = idle & ctrl.en & ~rst;
  assign txe       = idle;
  assign handshake = tx_valid & tx_ready;
  assign boundary  = tick & (tick_cnt == TICK_LAST);
  assign last_idx  = shadow_word ? 3'(UART_MAX_BITS - 1) : 3'(UART_MAX_BITS - 2);

  // Counters are held clear while idle, so every frame starts from a fresh bit period.
  uart_baud_gen u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (idle),
    .br_div (shadow_br_div),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (idle) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame parameters are captured at the handshake so later ctrl writes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data   <= '0;
      shadow_word   <= 1'b0;
      shadow_stop   <= 1'b0;
      shadow_br_div <= '0;
      bit_idx       <= '0;
      stop_cnt      <= 1'b0;
    end else if (handshake) begin
      shadow_data   <= tx_data;
      shadow_word   <= ctrl.word;
      shadow_stop   <= ctrl.stop;
      shadow_br_div <= ctrl.br_div;
      bit_idx       <= '0;
      stop_cnt      <= 1'b0;
    end else if (boundary) begin
      if (state == DATA) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP) begin
        stop_cnt <= ~stop_cnt;
      end
    end
  end

  always_comb begin
    state_next = state;
    tx         = IDLE_LEVEL;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = START;
        end
      end
      START: begin
        tx = ~IDLE_LEVEL;
        if (boundary) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shadow_data[bit_idx];
        if (boundary && (bit_idx == last_idx)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (boundary && (stop_cnt == shadow_stop)) begin
          state_next = IDLE;
          tx_done    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected line levels per bit period are
// queued at each handshake and compared at the first and last cycle of every bit.
module tb_uart_tx_serializer;
  import data_types_pkg::*;

  logic      clk;
  logic      rst;
  ctrl_reg_t ctrl;
  byte_t     tx_data;
  logic      tx_valid;
  logic      tx_ready;
  logic      tx;
  logic      txe;
  logic      tx_done;

  int        n_checks;
  int        n_fail;
  string     test_name;
  logic      exp_q[$];
  int        br;

  logic      hold_valid;
  int        chg_cyc;
  ctrl_reg_t chg_ctrl;
  logic      chg_valid;
  byte_t     chg_data;

  uart_tx_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .txe      (txe),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s/%s: observed %b expected %b", test_name, tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input byte_t data, input logic word, input logic stop);
    exp_q.push_back(1'b0);
    for (int i = 0; i < (word ? 8 : 7); i++) exp_q.push_back(data[i]);
    exp_q.push_back(1'b1);
    if (stop) exp_q.push_back(1'b1);
  endtask

  // Drives one handshake and returns the divider the frame was latched with.
  task automatic applyStimulus(input byte_t data, output int br_o);
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    checkOutput("ready_before_hs", tx_ready, 1'b1);
    pushFrame(data, ctrl.word, ctrl.stop);
    br_o = int'(ctrl.br_div);
    @(posedge clk);
  endtask

  task automatic checkFrame(input int br_v);
    int   p;
    int   total;
    int   b;
    logic expv;
    p     = 16 * (br_v + 1);
    total = exp_q.size() * p;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk);
      b = (cyc - 1) / p;
      if (cyc == b * p + 1) checkOutput($sformatf("bit%0d_first", b), tx, exp_q[0]);
      if (cyc == (b + 1) * p) begin
        expv = exp_q.pop_front();
        checkOutput($sformatf("bit%0d_last", b), tx, expv);
      end
      if (cyc == 1) begin
        checkOutput("txe_busy", txe, 1'b0);
        checkOutput("ready_busy", tx_ready, 1'b0);
        if (!hold_valid) tx_valid = 1'b0;
      end
      if (cyc == total - 1) checkOutput("done_early", tx_done, 1'b0);
      if (cyc == total) checkOutput("done_pulse", tx_done, 1'b1);
      if (chg_cyc != 0 && cyc == chg_cyc) begin
        ctrl     = chg_ctrl;
        tx_valid = chg_valid;
        tx_data  = chg_data;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    ctrl.en    = 1'b1;
    ctrl.word  = 1'b1;
    ctrl.stop  = 1'b0;
    ctrl.br_div = 8'd0;
    hold_valid = 1'b0;
    chg_cyc    = 0;
    chg_ctrl   = ctrl;
    chg_valid  = 1'b0;
    chg_data   = '0;

    test_name = "reset";
    repeat (3) @(negedge clk);
    checkOutput("tx", tx, 1'b1);
    checkOutput("txe", txe, 1'b1);
    checkOutput("ready", tx_ready, 1'b0);
    checkOutput("done", tx_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_release", tx_ready, 1'b1);

    test_name = "reset_mid_frame";
    applyStimulus(8'h00, br);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (39) @(negedge clk);
    checkOutput("tx_low_in_frame", tx, 1'b0);
    checkOutput("txe_in_frame", txe, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("tx_async", tx, 1'b1);
    checkOutput("txe_async", txe, 1'b1);
    checkOutput("ready_async", tx_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("ready_released", tx_ready, 1'b1);
    checkOutput("tx_released", tx, 1'b1);

    test_name = "8N1_A5";
    applyStimulus(8'hA5, br);
    checkFrame(br);

    test_name = "7N2_FF";
    ctrl.word   = 1'b0;
    ctrl.stop   = 1'b1;
    ctrl.br_div = 8'd3;
    applyStimulus(8'hFF, br);
    checkFrame(br);

    test_name = "back_to_back";
    ctrl.word   = 1'b1;
    ctrl.stop   = 1'b0;
    ctrl.br_div = 8'd0;
    hold_valid  = 1'b1;
    chg_cyc     = 5;
    chg_ctrl    = ctrl;
    chg_valid   = 1'b1;
    chg_data    = 8'hFF;
    applyStimulus(8'h00, br);
    checkFrame(br);
    @(negedge clk);
    checkOutput("gap_tx_high", tx, 1'b1);
    checkOutput("gap_ready", tx_ready, 1'b1);
    checkOutput("gap_txe", txe, 1'b1);
    checkOutput("gap_done_low", tx_done, 1'b0);
    pushFrame(8'hFF, ctrl.word, ctrl.stop);
    hold_valid = 1'b0;
    chg_cyc    = 0;
    @(posedge clk);
    checkFrame(0);

    test_name = "ctrl_change_mid_frame";
    ctrl.br_div     = 8'd1;
    chg_cyc         = 100;
    chg_ctrl        = ctrl;
    chg_ctrl.word   = 1'b0;
    chg_ctrl.br_div = 8'd0;
    chg_valid       = 1'b0;
    chg_data        = 8'h80;
    applyStimulus(8'h3C, br);
    checkFrame(br);
    chg_cyc = 0;
    test_name = "new_ctrl_7N1_80";
    applyStimulus(8'h80, br);
    checkFrame(br);

    test_name = "en_drop_mid_frame";
    ctrl.word     = 1'b1;
    ctrl.br_div   = 8'd0;
    chg_cyc       = 50;
    chg_ctrl      = ctrl;
    chg_ctrl.en   = 1'b0;
    chg_valid     = 1'b1;
    chg_data      = 8'h33;
    applyStimulus(8'h5A, br);
    checkFrame(br);
    chg_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      checkOutput($sformatf("blocked_ready_%0d", i), tx_ready, 1'b0);
      checkOutput($sformatf("blocked_txe_%0d", i), txe, 1'b1);
      checkOutput($sformatf("blocked_tx_%0d", i), tx, 1'b1);
    end
    tx_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
